scalar_rf_write_arbiter: RTL

//  Shares the single write port of the scalar register file among NUM_REQ writeback sources
//  (ALU, load unit, vector-to-scalar move): round-robin, valid/ready handshake.

---
 rtl/scalar_rf_write_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/scalar_rf_write_arbiter.sv
// scalar_rf_write_arbiter
// Round-robin arbiter for the single write port of the scalar register file,
// with a per-register pending-write scoreboard consulted by the issue stage.
module scalar_rf_write_arbiter #(
  parameter int BIT_NUMBER      = 32,
  parameter int ADDR_NUMBER     = 5,
  parameter int REGISTER_NUMBER = 16,
  parameter int NUM_REQ         = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDR_NUMBER-1:0]   req_addr,
  input  logic [NUM_REQ*BIT_NUMBER-1:0]    req_data,
  input  logic                             rsv_valid,
  input  logic [ADDR_NUMBER-1:0]           rsv_addr,
  input  logic [ADDR_NUMBER-1:0]           chk_addr_1,
  input  logic [ADDR_NUMBER-1:0]           chk_addr_2,
  output logic                             chk_busy_1,
  output logic                             chk_busy_2,
  output logic [REGISTER_NUMBER-1:0]       busy_vec,
  output logic                             rf_write_enable,
  output logic [ADDR_NUMBER-1:0]           rf_dest_addr,
  output logic [BIT_NUMBER-1:0]            rf_write_data,
  output logic                             err_addr
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so REGISTER_NUMBER == 2**ADDR_NUMBER still compares correctly.
  localparam logic [ADDR_NUMBER:0] REG_LIMIT = (ADDR_NUMBER + 1)'(REGISTER_NUMBER);

  logic [PTR_W-1:0]           ptr_reg, ptr_next;
  logic [REGISTER_NUMBER-1:0] busy_reg, busy_next;
  logic                       rf_we_reg;
  logic [ADDR_NUMBER-1:0]     rf_addr_reg;
  logic [BIT_NUMBER-1:0]      rf_data_reg;
  logic                       err_reg;

  logic [NUM_REQ-1:0]         grant;
  logic [PTR_W-1:0]           grant_idx;
  logic                       grant_any;
  int                         idx_int;
  logic [PTR_W-1:0]           idx_sel;

  logic [ADDR_NUMBER-1:0]     addr_arr [NUM_REQ];
  logic [BIT_NUMBER-1:0]      data_arr [NUM_REQ];
  logic [ADDR_NUMBER-1:0]     sel_addr;
  logic [BIT_NUMBER-1:0]      sel_data;
  logic                       xfer_legal;
  logic                       rsv_legal;

  logic [REGISTER_NUMBER-1:0] set_hit, clr_hit, chk1_hit, chk2_hit;

  // Unpack the flat requester buses into per-requester arrays.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*ADDR_NUMBER +: ADDR_NUMBER];
    assign data_arr[gi] = req_data[gi*BIT_NUMBER +: BIT_NUMBER];
  end

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx_int   = 0;
    idx_sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_int = int'(ptr_reg) + k;
      if (idx_int >= NUM_REQ) idx_int = idx_int - NUM_REQ;
      idx_sel = PTR_W'(idx_int);
      if (!grant_any && req_valid[idx_sel]) begin
        grant_any      = 1'b1;
        grant[idx_sel] = 1'b1;
        grant_idx      = idx_sel;
      end
    end
  end

  assign req_ready  = grant;
  assign sel_addr   = addr_arr[grant_idx];
  assign sel_data   = data_arr[grant_idx];
  // A grant is only ever given to a valid requester, so grant_any is the transfer.
  assign xfer_legal = grant_any && ({1'b0, sel_addr} < REG_LIMIT);
  assign rsv_legal  = rsv_valid && ({1'b0, rsv_addr} < REG_LIMIT);

  // Pointer moves just past the requester that completed a transfer.
  always_comb begin
    ptr_next = ptr_reg;
    if (grant_any) begin
      ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Per-register decode of reservation, writeback clear and operand checks.
  for (genvar gi = 0; gi < REGISTER_NUMBER; gi++) begin : g_reg
    assign set_hit[gi]  = rsv_legal  && (rsv_addr   == ADDR_NUMBER'(gi));
    assign clr_hit[gi]  = xfer_legal && (sel_addr   == ADDR_NUMBER'(gi));
    assign chk1_hit[gi] = (chk_addr_1 == ADDR_NUMBER'(gi));
    assign chk2_hit[gi] = (chk_addr_2 == ADDR_NUMBER'(gi));
  end

  // Set after clear so a same-cycle reservation keeps the register busy.
  assign busy_next = (busy_reg & ~clr_hit) | set_hit;

  // A register being written back this cycle is already free for the reader.
  assign chk_busy_1 = |(busy_reg & chk1_hit & ~clr_hit);
  assign chk_busy_2 = |(busy_reg & chk2_hit & ~clr_hit);

  // State update: pointer, scoreboard, register-file write stage and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg     <= '0;
      busy_reg    <= '0;
      rf_we_reg   <= 1'b0;
      rf_addr_reg <= '0;
      rf_data_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      ptr_reg   <= ptr_next;
      busy_reg  <= busy_next;
      rf_we_reg <= xfer_legal;
      if (xfer_legal) begin
        rf_addr_reg <= sel_addr;
        rf_data_reg <= sel_data;
      end
      err_reg <= (grant_any && !xfer_legal) || (rsv_valid && !rsv_legal);
    end
  end

  assign busy_vec        = busy_reg;
  assign rf_write_enable = rf_we_reg;
  assign rf_dest_addr    = rf_addr_reg;
  assign rf_write_data   = rf_data_reg;
  assign err_addr        = err_reg;

endmodule
